// File: rtl/fixed_point_mul_pipe.sv
// Three-stage signed Q(INTEGER).(FRACTION) multiplier with valid/ready flow control.
// Define FXP_MUL_SATURATE_EN to clamp overflowing results; otherwise they wrap.
module fixed_point_mul_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int INTEGER    = 8,
  parameter int FRACTION   = 8,
  parameter int ROUND      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  ovf
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int XW = PW + 1;
  localparam logic [XW-1:0] ROUND_ADD = (ROUND != 0) ? (XW'(1) << (FRACTION - 1)) : '0;

  if (DATA_WIDTH != INTEGER + FRACTION || FRACTION < 1) begin : g_bad_cfg
    $error("fixed_point_mul_pipe: DATA_WIDTH must equal INTEGER + FRACTION, FRACTION >= 1");
  end

  logic                         s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [DATA_WIDTH-1:0] a_q, b_q;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic [DATA_WIDTH-1:0]        out_q, res_d;
  logic                         ovf_q, ovf_d;
  logic signed [XW-1:0]         p_round, p_shift;
  logic signed [DATA_WIDTH-1:0] cand;
  logic                         adv;

  // One enable moves the whole pipe, so a stalled head freezes every stage.
  assign adv      = !s3_valid_q || out_ready;
  assign in_ready = adv;

  assign prod_d = PW'(a_q) * PW'(b_q);

  // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    p_round = XW'(prod_q) + ROUND_ADD;
    p_shift = p_round >>> FRACTION;
    cand    = p_shift[DATA_WIDTH-1:0];
    // The extra top bit keeps the rounding add from wrapping; any bit above the
    // candidate that disagrees with its sign means the value does not fit.
    ovf_d   = (p_shift != XW'(cand));
    res_d   = cand;
`ifdef FXP_MUL_SATURATE_EN
    if (ovf_d) begin
      res_d = p_round[XW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

  // NOTE: operand and product registers carry no reset; their valid bits already mark them as empty.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        a_q <= in1;
        b_q <= in2;
      end
      if (s1_valid_q) begin
        prod_q <= prod_d;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_point_mul_pipe.sv
// Scoreboard bench for fixed_point_mul_pipe: truncating and rounding instances share one stimulus
// stream; hand-computed results are queued on acceptance and popped by per-instance monitors.
module tb_fixed_point_mul_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         out_ready = 1'b1;
  logic         in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [W-1:0] out0, out1;

  always #5 clk = ~clk;

  fixed_point_mul_pipe #(.DATA_WIDTH(16), .INTEGER(8), .FRACTION(8), .ROUND(0)) dut_r0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in1(in1), .in2(in2),
    .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .ovf(ovf0));

  fixed_point_mul_pipe #(.DATA_WIDTH(16), .INTEGER(8), .FRACTION(8), .ROUND(1)) dut_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in1(in1), .in2(in2),
    .out_valid(out_valid1), .out_ready(out_ready), .out(out1), .ovf(ovf1));

`ifdef FXP_MUL_SATURATE_EN
  localparam logic [W-1:0] OV_A = 16'h7FFF, OV_B = 16'h7FFF, OV_C = 16'h7FFF;
`else
  localparam logic [W-1:0] OV_A = 16'hC800, OV_B = 16'h8000, OV_C = 16'hFF00;
`endif

  typedef struct {
    logic [W-1:0] a, b, r0, r1;
    logic         ov;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  vec_t vt[11];
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stall_lo = -1, stall_hi = -2;
  int   bub_start = 0;
  bit   chk_bubble = 1'b0;
  bit   acc_hist[1024];
  bit   prev_stall = 1'b0;
  bit   saw_in_ready_low = 1'b0;
  logic [W-1:0] prev_out0, prev_out1;
  logic prev_ovf0, prev_ovf1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One stimulus cycle: move to the falling edge, apply the out_ready schedule, run per-cycle checks.
  task automatic drive_cycle();
    @(negedge clk);
    cyc++;
    out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    #1;
    check("in_ready_r0", 32'(in_ready0), 32'(!out_valid0 || out_ready));
    check("in_ready_r1", 32'(in_ready1), 32'(!out_valid1 || out_ready));
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid0), 32'd1);
      check("hold_out_r0", 32'(out0), 32'(prev_out0));
      check("hold_ovf_r0", 32'(ovf0), 32'(prev_ovf0));
      check("hold_out_r1", 32'(out1), 32'(prev_out1));
      check("hold_ovf_r1", 32'(ovf1), 32'(prev_ovf1));
    end
    if (out_valid0 && !in_ready0) saw_in_ready_low = 1'b1;
    prev_stall = out_valid0 && !out_ready;
    prev_out0  = out0;
    prev_ovf0  = ovf0;
    prev_out1  = out1;
    prev_ovf1  = ovf1;
    if (chk_bubble && cyc - 3 >= bub_start)
      check("bubble_valid", 32'(out_valid0), 32'(acc_hist[cyc-3]));
    acc_hist[cyc] = 1'b0;
  endtask

  task automatic idle();
    drive_cycle();
    in_valid = 1'b0;
  endtask

  task automatic send(input int idx);
    int waited = 0;
    drive_cycle();
    in_valid = 1'b1;
    in1 = vt[idx].a;
    in2 = vt[idx].b;
    #1;
    while (!in_ready0 && waited < 50) begin
      drive_cycle();
      #1;
      waited++;
    end
    if (!in_ready0) begin
      check("accept_timeout", 32'(in_ready0), 32'd1);
    end else begin
      q0.push_back('{data: vt[idx].r0, ovf: vt[idx].ov});
      q1.push_back('{data: vt[idx].r1, ovf: vt[idx].ov});
      acc_hist[cyc] = 1'b1;
    end
  endtask

  // Monitors: a result transfers when out_valid && out_ready are both high before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL r0_extra_result: got out=0x%0h with nothing expected", out0);
        end else begin
          e0 = q0.pop_front();
          check("r0_out", 32'(out0), 32'(e0.data));
          check("r0_ovf", 32'(ovf0), 32'(e0.ovf));
        end
      end
      if (!rst && out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL r1_extra_result: got out=0x%0h with nothing expected", out1);
        end else begin
          e1 = q1.pop_front();
          check("r1_out", 32'(out1), 32'(e1.data));
          check("r1_ovf", 32'(ovf1), 32'(e1.ovf));
        end
      end
    end
  end

  initial begin
    //            a         b         trunc     round     ovf
    vt[0]  = '{16'h0180, 16'h0200, 16'h0300, 16'h0300, 1'b0};  //  1.5 *  2
    vt[1]  = '{16'hFE80, 16'h0200, 16'hFD00, 16'hFD00, 1'b0};  // -1.5 *  2
    vt[2]  = '{16'h0001, 16'h0080, 16'h0000, 16'h0001, 1'b0};  // exact half LSB
    vt[3]  = '{16'h0001, 16'h007F, 16'h0000, 16'h0000, 1'b0};  // just under half
    vt[4]  = '{16'h6400, 16'h0200, OV_A,     OV_A,     1'b1};  // 100 * 2
    vt[5]  = '{16'hFF00, 16'h8000, OV_B,     OV_B,     1'b1};  // -1 * -128
    vt[6]  = '{16'hFFFF, 16'h0080, 16'hFFFF, 16'h0000, 1'b0};  // negative half LSB
    vt[7]  = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};  // tiny negative
    vt[8]  = '{16'h7FFF, 16'h0100, 16'h7FFF, 16'h7FFF, 1'b0};  // max * 1
    vt[9]  = '{16'h8000, 16'h0100, 16'h8000, 16'h8000, 1'b0};  // min * 1
    vt[10] = '{16'h7FFF, 16'h7FFF, OV_C,     OV_C,     1'b1};  // max * max

    rst = 1'b1;
    repeat (2) idle();
    check("rst_valid_r0", 32'(out_valid0), 32'd0);
    check("rst_out_r0", 32'(out0), 32'd0);
    check("rst_ovf_r0", 32'(ovf0), 32'd0);
    check("rst_in_ready_r0", 32'(in_ready0), 32'd1);
    check("rst_valid_r1", 32'(out_valid1), 32'd0);
    check("rst_out_r1", 32'(out1), 32'd0);
    rst = 1'b0;

    // Directed products, no backpressure.
    for (int i = 0; i < 11; i++) send(i);
    repeat (6) idle();
    check("directed_drain_r0", 32'(q0.size()), 32'd0);
    check("directed_drain_r1", 32'(q1.size()), 32'd0);

    // Six back-to-back pairs, out_ready low on phase cycles 2..9.
    saw_in_ready_low = 1'b0;
    stall_lo = cyc + 2;
    stall_hi = cyc + 9;
    for (int i = 0; i < 6; i++) send(i);
    repeat (14) idle();
    check("bp_in_ready_fell", 32'(saw_in_ready_low), 32'd1);
    check("bp_drain_r0", 32'(q0.size()), 32'd0);
    check("bp_drain_r1", 32'(q1.size()), 32'd0);

    // Alternating bubbles: out_valid must echo the accept pattern three cycles later.
    chk_bubble = 1'b1;
    bub_start = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      send(i);
      idle();
    end
    repeat (5) idle();
    chk_bubble = 1'b0;
    check("bubble_drain_r0", 32'(q0.size()), 32'd0);

    // Fill all three stages under stall, then reset mid-stream.
    stall_lo = cyc + 1;
    stall_hi = cyc + 1000;
    for (int i = 0; i < 3; i++) send(6 + i);
    drive_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    stall_hi = cyc;
    prev_stall = 1'b0;
    q0.delete();
    q1.delete();
    drive_cycle();
    rst = 1'b0;
    check("midrst_valid_r0", 32'(out_valid0), 32'd0);
    check("midrst_out_r0", 32'(out0), 32'd0);
    check("midrst_ovf_r0", 32'(ovf0), 32'd0);
    check("midrst_valid_r1", 32'(out_valid1), 32'd0);
    check("midrst_out_r1", 32'(out1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      check("post_rst_quiet_r0", 32'(out_valid0), 32'd0);
      check("post_rst_quiet_r1", 32'(out_valid1), 32'd0);
    end

    // Pipe must still work after the reset.
    send(4);
    repeat (6) idle();
    check("final_drain_r0", 32'(q0.size()), 32'd0);
    check("final_drain_r1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
